// File: rtl/clz_restoring_divider_pkg.sv
// Shared types and constants for the CLZ-assisted restoring divider.
package clz_restoring_divider_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CLZ_W  = $clog2(DIV_DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    typedef logic [DIV_CLZ_W:0] div_cnt_t;

endpackage

// File: rtl/clz_restoring_divider_if.sv
// Request/response bundle between the div unit (master) and the divider (slave).
interface clz_restoring_divider_if
    import clz_restoring_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_W
);
    localparam int CLZ_W = $clog2(DATA_WIDTH);

    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [CLZ_W-1:0]      dividend_CLZ;
    logic [DATA_WIDTH-1:0] divisor;
    logic [CLZ_W-1:0]      divisor_CLZ;
    logic                  divisor_is_zero;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  done;

    modport master (
        output start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero,
        input  quotient, remainder, done
    );

    modport slave (
        input  start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero,
        output quotient, remainder, done
    );
endinterface

// File: rtl/restoring_div_step.sv
// One restoring division step: trial-subtract the aligned divisor from the partial remainder.
module restoring_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] sdiv,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic                  q_bit
);
    assign q_bit    = (rem >= sdiv);
    assign rem_next = q_bit ? (rem - sdiv) : rem;
endmodule

// File: rtl/clz_restoring_divider.sv
// Iterative restoring unsigned divider; leading-zero counts skip the all-zero quotient prefix.
// Define DIVIDER_RADIX4_EN to retire two quotient bits per BUSY cycle.
module clz_restoring_divider
    import clz_restoring_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_W
) (
    input logic                   clk,
    input logic                   rst,
    clz_restoring_divider_if.slave bus
);
    localparam int CLZ_W = $clog2(DATA_WIDTH);
    localparam int CNT_W = CLZ_W + 1;

    div_state_t            state;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] sdiv;
    logic [DATA_WIDTH-1:0] q;
    logic [CNT_W-1:0]      cnt;
    logic                  done;

    // Divisor is pre-shifted so its leading one lines up with the dividend's.
    logic [CLZ_W-1:0] shamt;
    logic [CNT_W-1:0] n_steps;
    assign shamt   = bus.divisor_CLZ - bus.dividend_CLZ;
    assign n_steps = {1'b0, shamt} + CNT_W'(1);

    logic [DATA_WIDTH-1:0] rem1;
    logic                  bit1;
    logic                  last_step;

    restoring_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step0 (
        .rem      (rem),
        .sdiv     (sdiv),
        .rem_next (rem1),
        .q_bit    (bit1)
    );

`ifdef DIVIDER_RADIX4_EN
    logic [DATA_WIDTH-1:0] rem2;
    logic                  bit2;

    restoring_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step1 (
        .rem      (rem1),
        .sdiv     (sdiv >> 1),
        .rem_next (rem2),
        .q_bit    (bit2)
    );

    // Odd remaining count takes a single step, so every later cycle takes two.
    assign last_step = (cnt <= CNT_W'(2));
`else
    assign last_step = (cnt == CNT_W'(1));
`endif

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            q     <= '0;
            rem   <= '0;
            sdiv  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem <= bus.dividend;
                        if (bus.divisor_is_zero) begin
                            q     <= '1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (bus.divisor_CLZ < bus.dividend_CLZ) begin
                            q     <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            q     <= '0;
                            sdiv  <= bus.divisor << shamt;
                            cnt   <= n_steps;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
`ifdef DIVIDER_RADIX4_EN
                    if (cnt[0]) begin
                        rem  <= rem1;
                        q    <= {q[DATA_WIDTH-2:0], bit1};
                        sdiv <= sdiv >> 1;
                        cnt  <= cnt - CNT_W'(1);
                    end else begin
                        rem  <= rem2;
                        q    <= {q[DATA_WIDTH-3:0], bit1, bit2};
                        sdiv <= sdiv >> 2;
                        cnt  <= cnt - CNT_W'(2);
                    end
`else
                    rem  <= rem1;
                    q    <= {q[DATA_WIDTH-2:0], bit1};
                    sdiv <= sdiv >> 1;
                    cnt  <= cnt - CNT_W'(1);
`endif
                    if (last_step) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient  = q;
    assign bus.remainder = rem;
    assign bus.done      = done;
endmodule

// File: tb/tb_clz_restoring_divider.sv
// Scoreboard bench for clz_restoring_divider: directed vectors, decoupled monitor.
module tb_clz_restoring_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clz_restoring_divider_if #(.DATA_WIDTH(32)) dif ();

    clz_restoring_divider #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--)
            if (v[i]) return 5'(31 - i);
        return 5'd31;
    endfunction

    // Monitor: every done pulse must match the oldest expectation and last one cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dif.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " q"}, {32'd0, dif.quotient}, {32'd0, e.q});
                    check({e.name, " r"}, {32'd0, dif.remainder}, {32'd0, e.r});
                    check({e.name, " done_cycle"}, 64'(cyc), 64'(e.due));
                    @(negedge clk);
                    check({e.name, " done_pulse"}, {63'd0, dif.done}, 64'd0);
                end
            end
        end
    end

    task automatic drive_ops(input logic [31:0] a, input logic [31:0] b);
        dif.dividend        = a;
        dif.dividend_CLZ    = clz(a);
        dif.divisor         = b;
        dif.divisor_CLZ     = clz(b);
        dif.divisor_is_zero = (b == 32'd0);
    endtask

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int lat1, input int lat4, input bit expect_done,
                         input bit poke_busy);
        int lat;
`ifdef DIVIDER_RADIX4_EN
        lat = lat4;
`else
        lat = lat1;
`endif
        @(negedge clk);
        dif.start = 1'b1;
        drive_ops(a, b);
        if (expect_done) sb.push_back('{eq, er, cyc + lat, name});
        @(negedge clk);
        dif.start = 1'b0;
        drive_ops($urandom, $urandom);
        if (poke_busy) begin
            @(negedge clk);
            dif.start = 1'b1;
            drive_ops(32'd3, 32'd1);
            @(negedge clk);
            @(negedge clk);
            dif.start = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check({name, " drained"}, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input int lat1, input int lat4);
        issue(name, a, b, eq, er, lat1, lat4, 1'b1, 1'b0);
        drain(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start = 1'b0;
        drive_ops(32'd0, 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset done", {63'd0, dif.done}, 64'd0);
        check("reset q", {32'd0, dif.quotient}, 64'd0);
        check("reset r", {32'd0, dif.remainder}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("100/7",          32'd100,        32'd7,       32'd14,         32'd2,      6, 4);
        run("0x1234/0",       32'h1234,       32'd0,       32'hFFFF_FFFF,  32'h1234,   1, 1);
        run("5/9",            32'd5,          32'd9,       32'd0,          32'd5,      1, 1);
        run("0/1",            32'd0,          32'd1,       32'd0,          32'd0,      2, 2);
        run("ffffffff/1",     32'hFFFF_FFFF,  32'd1,       32'hFFFF_FFFF,  32'd0,     33, 17);
        run("80000000/3",     32'h8000_0000,  32'd3,       32'h2AAA_AAAA,  32'd2,     32, 17);
        run("1000/10",        32'd1000,       32'd10,      32'd100,        32'd0,      8, 5);
        run("7/7",            32'd7,          32'd7,       32'd1,          32'd0,      2, 2);
        run("255/16",         32'd255,        32'd16,      32'd15,         32'd15,     5, 3);
        run("deadbeef/10000", 32'hDEAD_BEEF,  32'h1_0000,  32'h0000_DEAD,  32'hBEEF,  17, 9);
        run("12345/0",        32'd12345,      32'd0,       32'hFFFF_FFFF,  32'd12345,  1, 1);
        run("0/80000000",     32'd0,          32'h8000_0000, 32'd0,        32'd0,      1, 1);

        // Abort 100/7 with reset asserted in cycle 3: no done pulse may follow.
        issue("abort", 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort q", {32'd0, dif.quotient}, 64'd0);
        check("abort r", {32'd0, dif.remainder}, 64'd0);
        check("abort done", {63'd0, dif.done}, 64'd0);
        repeat (10) @(negedge clk);

        // Start pulses while busy must not spawn another result.
        issue("50/5", 32'd50, 32'd5, 32'd10, 32'd0, 5, 3, 1'b1, 1'b1);
        drain("50/5");
        repeat (40) @(negedge clk);
        run("after 50/5", 32'd99, 32'd4, 32'd24, 32'd3, 6, 4);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
